// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared definitions for the run sequencer.
package seq_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        DONE    = 3'd4
    } seq_state_t;
    localparam int MEM_LAT_DEFAULT = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    assign count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + W'(1) : count_q;
    always_ff @(posedge Clk) begin
        count_q <= Reset ? '0 : count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: run sequencer owning Start/Done, PC init, memory-wait stalls and
// once-per-instruction write gating, plus cycle/instruction performance counters.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack_i,
    input  logic             MemRd_i,
    input  logic             MemWr_i,
    output logic             PcInit,
    output logic             PcEn,
    output logic             RegWrGate,
    output logic             MemWrGate,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstCnt
);
    localparam logic [3:0] WAIT_LD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
    seq_state_t state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       adv, pc_init;
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        adv     = 1'b0;
        pc_init = 1'b0;
        unique case (state_q)
            IDLE:    state_d = Start ? INIT : IDLE;
            INIT: begin
                pc_init = 1'b1;
                state_d = Start ? INIT : EXEC;
            end
            EXEC: begin
                if (Ack_i) begin
                    state_d = DONE;
                end else if ((MemRd_i || MemWr_i) && MEM_LAT > 0) begin
                    state_d = MEMWAIT;
                    wait_d  = WAIT_LD;
                end else begin
                    adv = 1'b1;
                end
            end
            // Decoder inputs are ignored here; PcEn=0 keeps the instruction stable.
            MEMWAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    adv     = 1'b1;
                    state_d = EXEC;
                end
            end
            DONE:    state_d = Start ? INIT : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        state_q <= Reset ? IDLE : state_d;
        wait_q  <= Reset ? 4'd0 : wait_d;
    end
    assign PcInit    = pc_init;
    assign PcEn      = adv;
    assign RegWrGate = adv;
    assign MemWrGate = adv;
    assign Busy      = (state_q == EXEC) || (state_q == MEMWAIT);
    assign Done      = (state_q == DONE);
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (state_q == INIT),
        .inc   (Busy),
        .count (CycleCnt)
    );
    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (state_q == INIT),
        .inc   (adv),
        .count (InstCnt)
    );
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed scenarios on three sequencer instances sharing stimulus
// (MEM_LAT=2/CNT_W=16, MEM_LAT=0, and CNT_W=4 for saturation).
module tb_seq_ctrl;
    logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Ack = 1'b0, Rd = 1'b0, Wr = 1'b0;
    logic a_pi, a_pe, a_rg, a_mg, a_busy, a_done;
    logic [15:0] a_cyc, a_inst;
    logic b_pi, b_pe, b_rg, b_mg, b_busy, b_done;
    logic [15:0] b_cyc, b_inst;
    logic c_pi, c_pe, c_rg, c_mg, c_busy, c_done;
    logic [3:0] c_cyc, c_inst;
    int n_chk = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    seq_ctrl #(.MEM_LAT(2), .CNT_W(16)) u_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack_i(Ack), .MemRd_i(Rd), .MemWr_i(Wr),
        .PcInit(a_pi), .PcEn(a_pe), .RegWrGate(a_rg), .MemWrGate(a_mg),
        .Busy(a_busy), .Done(a_done), .CycleCnt(a_cyc), .InstCnt(a_inst));
    seq_ctrl #(.MEM_LAT(0), .CNT_W(16)) u_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack_i(Ack), .MemRd_i(Rd), .MemWr_i(Wr),
        .PcInit(b_pi), .PcEn(b_pe), .RegWrGate(b_rg), .MemWrGate(b_mg),
        .Busy(b_busy), .Done(b_done), .CycleCnt(b_cyc), .InstCnt(b_inst));
    seq_ctrl #(.MEM_LAT(2), .CNT_W(4)) u_c (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack_i(Ack), .MemRd_i(Rd), .MemWr_i(Wr),
        .PcInit(c_pi), .PcEn(c_pe), .RegWrGate(c_rg), .MemWrGate(c_mg),
        .Busy(c_busy), .Done(c_done), .CycleCnt(c_cyc), .InstCnt(c_inst));

    // Drive one cycle's inputs after the falling edge, then settle before sampling.
    task automatic cyc(input logic rst, input logic st, input logic ack, input logic rd, input logic wr);
        @(negedge Clk);
        Reset = rst; Start = st; Ack = ack; Rd = rd; Wr = wr;
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic begin_run();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({a_pi, a_pe, a_rg, a_mg, a_busy, a_done} !== 6'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 000000", {a_pi, a_pe, a_rg, a_mg, a_busy, a_done}); end
        n_chk++; if (a_cyc !== 16'd0 || a_inst !== 16'd0) begin n_fail++; $display("FAIL reset_cnts: got cyc=%0d inst=%0d expected 0/0", a_cyc, a_inst); end
    endtask

    task automatic test_basic();
        int pi_n = 0, pe_n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            pi_n += int'(a_pi);
        end
        cyc(0, 0, 0, 0, 0);
        pi_n += int'(a_pi);
        n_chk++; if (pi_n !== 3) begin n_fail++; $display("FAIL basic_pcinit_cycles: got %0d expected 3", pi_n); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            pe_n += int'(a_pe);
        end
        n_chk++; if (pe_n !== 4) begin n_fail++; $display("FAIL basic_pcen_cycles: got %0d expected 4", pe_n); end
        cyc(0, 0, 1, 0, 0);
        n_chk++; if ({a_pe, a_rg, a_mg, a_done} !== 4'b0) begin n_fail++; $display("FAIL basic_halt_gates: got %b expected 0000", {a_pe, a_rg, a_mg, a_done}); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b expected 1/0", a_done, a_busy); end
        n_chk++; if (a_inst !== 16'd4 || a_cyc !== 16'd5) begin n_fail++; $display("FAIL basic_counts: got inst=%0d cyc=%0d expected 4/5", a_inst, a_cyc); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_done !== 1'b1 || a_inst !== 16'd4) begin n_fail++; $display("FAIL basic_done_hold: got done=%b inst=%0d expected 1/4", a_done, a_inst); end
    endtask

    task automatic test_mem();
        int rg_n = 0;
        do_reset();
        begin_run();
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_pe !== 1'b1) begin n_fail++; $display("FAIL mem_alu1_pcen: got %b expected 1", a_pe); end
        cyc(0, 0, 0, 1, 0);
        n_chk++; if ({a_pe, a_rg} !== 2'b00) begin n_fail++; $display("FAIL mem_load_c1: got pe/rg=%b expected 00", {a_pe, a_rg}); end
        rg_n += int'(a_rg);
        cyc(0, 0, 1, 1, 0);
        n_chk++; if ({a_pe, a_rg, a_busy} !== 3'b001) begin n_fail++; $display("FAIL mem_load_c2: got pe/rg/busy=%b expected 001", {a_pe, a_rg, a_busy}); end
        rg_n += int'(a_rg);
        cyc(0, 0, 0, 1, 0);
        n_chk++; if ({a_pe, a_rg, a_mg} !== 3'b111) begin n_fail++; $display("FAIL mem_load_c3: got pe/rg/mg=%b expected 111", {a_pe, a_rg, a_mg}); end
        rg_n += int'(a_rg);
        n_chk++; if (rg_n !== 1) begin n_fail++; $display("FAIL mem_regwr_pulses: got %0d expected 1", rg_n); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_pe !== 1'b1) begin n_fail++; $display("FAIL mem_alu2_pcen: got %b expected 1", a_pe); end
        cyc(0, 0, 1, 0, 0);
        n_chk++; if (a_inst !== 16'd3 || a_cyc !== 16'd5) begin n_fail++; $display("FAIL mem_counts: got inst=%0d cyc=%0d expected 3/5", a_inst, a_cyc); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL mem_done: got %b expected 1", a_done); end
    endtask

    task automatic test_lat0();
        do_reset();
        begin_run();
        cyc(0, 0, 0, 0, 1);
        n_chk++; if ({b_pe, b_mg, b_rg} !== 3'b111) begin n_fail++; $display("FAIL lat0_store_gates: got pe/mg/rg=%b expected 111", {b_pe, b_mg, b_rg}); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (b_pe !== 1'b1 || b_inst !== 16'd1 || b_cyc !== 16'd1) begin n_fail++; $display("FAIL lat0_no_wait: got pe=%b inst=%0d cyc=%0d expected 1/1/1", b_pe, b_inst, b_cyc); end
        n_chk++; if (a_pe !== 1'b0) begin n_fail++; $display("FAIL lat2_store_stall: got pe=%b expected 0", a_pe); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        begin_run();
        cyc(0, 1, 0, 0, 0);
        n_chk++; if (a_pe !== 1'b1 || a_pi !== 1'b0) begin n_fail++; $display("FAIL exec_start_ignored: got pe=%b pi=%b expected 1/0", a_pe, a_pi); end
        cyc(0, 1, 0, 1, 0);
        n_chk++; if (a_busy !== 1'b1 || a_pi !== 1'b0 || a_inst !== 16'd1) begin n_fail++; $display("FAIL exec_start_stay: got busy=%b pi=%b inst=%0d expected 1/0/1", a_busy, a_pi, a_inst); end
        cyc(1, 1, 0, 0, 0);
        n_chk++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL memwait_entered: got busy=%b expected 1", a_busy); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if ({a_pi, a_pe, a_rg, a_mg, a_busy, a_done} !== 6'b0) begin n_fail++; $display("FAIL midreset_outs: got %b expected 000000", {a_pi, a_pe, a_rg, a_mg, a_busy, a_done}); end
        n_chk++; if (a_cyc !== 16'd0 || a_inst !== 16'd0) begin n_fail++; $display("FAIL midreset_cnts: got cyc=%0d inst=%0d expected 0/0", a_cyc, a_inst); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_pe !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got pe=%b busy=%b expected 0/0", a_pe, a_busy); end
    endtask

    task automatic test_rerun();
        do_reset();
        begin_run();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        n_chk++; if (a_done !== 1'b1 || a_inst !== 16'd1 || a_cyc !== 16'd2) begin n_fail++; $display("FAIL run1_done: got done=%b inst=%0d cyc=%0d expected 1/1/2", a_done, a_inst, a_cyc); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_pi !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL rerun_init: got pi=%b done=%b expected 1/0", a_pi, a_done); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_inst !== 16'd0 || a_cyc !== 16'd0) begin n_fail++; $display("FAIL rerun_clear: got inst=%0d cyc=%0d expected 0/0", a_inst, a_cyc); end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (a_done !== 1'b1 || a_inst !== 16'd2 || a_cyc !== 16'd3) begin n_fail++; $display("FAIL run2_counts: got done=%b inst=%0d cyc=%0d expected 1/2/3", a_done, a_inst, a_cyc); end
    endtask

    task automatic test_sat();
        do_reset();
        begin_run();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (i == 15) begin
                n_chk++; if (c_inst !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got inst=%0d expected 15", c_inst); end
            end
        end
        cyc(0, 0, 1, 0, 0);
        n_chk++; if (c_inst !== 4'd15 || c_cyc !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got inst=%0d cyc=%0d expected 15/15", c_inst, c_cyc); end
        n_chk++; if (a_inst !== 16'd20 || a_cyc !== 16'd20) begin n_fail++; $display("FAIL wide_counts: got inst=%0d cyc=%0d expected 20/20", a_inst, a_cyc); end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (c_done !== 1'b1 || c_cyc !== 4'd15 || a_cyc !== 16'd21) begin n_fail++; $display("FAIL sat_done: got done=%b ccyc=%0d acyc=%0d expected 1/15/21", c_done, c_cyc, a_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mem();
        test_lat0();
        test_reset_mid();
        test_rerun();
        test_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
